// File: rtl/wb_port_arbiter_if.sv
// Write-back arbitration bus: MEM/WB and multi-cycle sources in, register file
// write port and pipeline stall out.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 20,
  parameter int REG_W  = 3
);
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              mc_valid;
  logic              mc_ready;
  logic [REG_W-1:0]  mc_rd;
  logic [DATA_W-1:0] mc_data;
  logic              pipe_stall;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    input  mc_ready, pipe_stall, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    output mc_ready, pipe_stall, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between MEM/WB (priority) and a queued
// multi-cycle unit, with an age-based forced drain that stalls the pipeline.
module wb_port_arbiter #(
  parameter int DATA_W   = 20,
  parameter int REG_W    = 3,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  wb_port_arbiter_if.slave        bus,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);

  logic [REG_W+DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [AGE_W-1:0]        age;

  logic                    rf_we_p1;
  logic [REG_W-1:0]        rf_waddr_p1;
  logic [DATA_W-1:0]       rf_wdata_p1;

  logic                    have_head;
  logic                    starve;
  logic                    mc_ready_c;
  logic                    push;
  logic                    grant_fifo;
  logic                    grant_wb;
  logic [REG_W-1:0]        head_rd;
  logic [DATA_W-1:0]       head_data;

  // ---- p0: grant decision from registered queue state ----
  always_comb begin
    have_head  = (count != '0);
    starve     = have_head && (age >= AGE_MAX);
    mc_ready_c = !reset && (count < FULL_CNT);
    push       = bus.mc_valid && mc_ready_c;
    // A starving head wins even over a valid MEM/WB, which is held by the stall.
    grant_fifo = !reset && (starve || (!bus.wb_valid && have_head));
    grant_wb   = !reset && !starve && bus.wb_valid;
    {head_rd, head_data} = mem[rd_ptr];
  end

  assign bus.mc_ready   = mc_ready_c;
  assign bus.pipe_stall = !reset && starve;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {bus.mc_rd, bus.mc_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (grant_fifo) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, grant_fifo})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Age tracks only the current head; a pop hands the next entry a fresh count.
      if (grant_fifo || !have_head) begin
        age <= '0;
      end else if (age < AGE_MAX) begin
        age <= age + 1'b1;
      end
    end
  end

  // ---- p1: registered register-file write port ----
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_p1    <= 1'b0;
      rf_waddr_p1 <= '0;
      rf_wdata_p1 <= '0;
    end else begin
      rf_we_p1 <= grant_fifo || grant_wb;
      if (grant_fifo) begin
        rf_waddr_p1 <= head_rd;
        rf_wdata_p1 <= head_data;
      end else if (grant_wb) begin
        rf_waddr_p1 <= bus.wb_rd;
        rf_wdata_p1 <= bus.wb_data;
      end
    end
  end

  assign bus.rf_we    = rf_we_p1;
  assign bus.rf_waddr = rf_waddr_p1;
  assign bus.rf_wdata = rf_wdata_p1;
  assign fifo_count   = count;
endmodule
